// File: rtl/sdcard_clkgen_pkg.sv
// Shared types and constants for the multi-slot SD clock generator.
// Channel state encoding, reset divider and a small state-classification helper.
package sdcard_clkgen_pkg;

    typedef enum logic [1:0] {
        CH_OFF  = 2'd0,
        CH_LOW  = 2'd1,
        CH_HIGH = 2'd2,
        CH_PARK = 2'd3
    } ch_state_e;

    // 400 kHz identification clock from a 100 MHz PCLK
    localparam logic [15:0] DEFAULT_DIV = 16'd124;

    function automatic logic is_running(input ch_state_e state);
        return (state == CH_LOW) || (state == CH_HIGH);
    endfunction

endpackage

// File: rtl/sdcard_clkgen_channel.sv
// One SD clock channel: divider FSM, glitch-free divider switch at falling edges,
// park-low stop behaviour and a saturating stability counter.
module sdcard_clkgen_channel
    import sdcard_clkgen_pkg::*;
#(
    parameter int                DIV_W        = 16,
    parameter logic [DIV_W-1:0]  DEFAULT_DIV  = DIV_W'(16'd124),
    parameter int                STABLE_EDGES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_pause,
    input  logic             i_power_down,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_div_load,
    output logic             o_sd_clk,
    output logic             o_rise,
    output logic             o_fall,
    output logic             o_ack,
    output logic             o_stable,
    output logic             o_running
);

    localparam int              SW       = $clog2(STABLE_EDGES + 1);
    localparam logic [SW-1:0]   STAB_MAX = SW'(STABLE_EDGES);

    ch_state_e        r_state, w_state_n;
    logic [DIV_W-1:0] r_cnt, w_cnt_n;
    logic [DIV_W-1:0] r_a, w_a_n;
    logic [DIV_W-1:0] r_p, w_p_n;
    logic             r_pend, w_pend_n;
    logic [SW-1:0]    r_stab, w_stab_n;
    logic             r_clk, w_clk_n;
    logic             r_rise, r_fall, r_ack, r_stable, r_running;
    logic             w_run, w_cnt_zero, w_apply, w_rise_evt;
    logic [DIV_W-1:0] w_reload;

    // Next-state, counter, divider and stability logic for the channel
    always_comb begin
        w_run      = i_en & ~i_pause & ~i_power_down;
        w_cnt_zero = (r_cnt == {DIV_W{1'b0}});
        w_reload   = r_pend ? r_p : r_a;
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_clk_n    = r_clk;
        w_apply    = 1'b0;
        w_rise_evt = 1'b0;

        if (i_power_down && (r_state != CH_OFF)) begin
            // forced stop mid-phase; any pending divider is applied once parked in CH_OFF
            w_state_n = CH_OFF;
            w_clk_n   = 1'b0;
            w_cnt_n   = r_a;
        end else begin
            case (r_state)
                CH_OFF: begin
                    w_apply   = r_pend;
                    w_cnt_n   = w_reload;
                    w_clk_n   = 1'b0;
                    w_state_n = w_run ? CH_LOW : CH_OFF;
                end
                CH_LOW: begin
                    if (!w_run) begin
                        w_state_n = CH_OFF;
                        w_cnt_n   = r_a;
                    end else if (w_cnt_zero) begin
                        w_state_n  = CH_HIGH;
                        w_clk_n    = 1'b1;
                        w_cnt_n    = r_a;
                        w_rise_evt = 1'b1;
                    end else begin
                        w_cnt_n = r_cnt - DIV_W'(1);
                    end
                end
                CH_HIGH: begin
                    if (w_cnt_zero) begin
                        w_clk_n   = 1'b0;
                        w_apply   = r_pend;
                        w_cnt_n   = w_reload;
                        w_state_n = w_run ? CH_LOW : CH_OFF;
                    end else begin
                        w_cnt_n   = r_cnt - DIV_W'(1);
                        w_state_n = w_run ? CH_HIGH : CH_PARK;
                    end
                end
                CH_PARK: begin
                    if (w_cnt_zero) begin
                        w_clk_n   = 1'b0;
                        w_apply   = r_pend;
                        w_cnt_n   = w_reload;
                        w_state_n = CH_OFF;
                    end else begin
                        w_cnt_n = r_cnt - DIV_W'(1);
                    end
                end
                default: begin
                    w_state_n = CH_OFF;
                    w_clk_n   = 1'b0;
                    w_cnt_n   = r_a;
                end
            endcase
        end

        w_a_n = w_apply ? r_p : r_a;
        if (i_div_load) begin
            w_p_n    = i_div;
            w_pend_n = 1'b1;
        end else begin
            w_p_n    = r_p;
            w_pend_n = r_pend & ~w_apply;
        end

        if (w_apply || i_power_down || (w_state_n == CH_OFF) || (w_state_n == CH_PARK)) begin
            w_stab_n = {SW{1'b0}};
        end else if (w_rise_evt && (r_stab != STAB_MAX)) begin
            w_stab_n = r_stab + SW'(1);
        end else begin
            w_stab_n = r_stab;
        end
    end

    // Channel state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= CH_OFF;
            r_cnt     <= DEFAULT_DIV;
            r_a       <= DEFAULT_DIV;
            r_p       <= DEFAULT_DIV;
            r_pend    <= 1'b0;
            r_stab    <= {SW{1'b0}};
            r_clk     <= 1'b0;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
            r_ack     <= 1'b0;
            r_stable  <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_a       <= w_a_n;
            r_p       <= w_p_n;
            r_pend    <= w_pend_n;
            r_stab    <= w_stab_n;
            r_clk     <= w_clk_n;
            r_rise    <= w_clk_n & ~r_clk;
            r_fall    <= ~w_clk_n & r_clk;
            r_ack     <= w_apply;
            r_stable  <= (w_stab_n == STAB_MAX);
            r_running <= is_running(w_state_n);
        end
    end

    assign o_sd_clk  = r_clk;
    assign o_rise    = r_rise;
    assign o_fall    = r_fall;
    assign o_ack     = r_ack;
    assign o_stable  = r_stable;
    assign o_running = r_running;

endmodule

// File: rtl/sdcard_multi_clock_generator.sv
// NUM_CH independent SD card clocks derived from PCLK, one divider channel per slot,
// with a shared power-down that forces every channel off.
module sdcard_multi_clock_generator
    import sdcard_clkgen_pkg::*;
#(
    parameter int               NUM_CH       = 2,
    parameter int               DIV_W        = 16,
    parameter logic [DIV_W-1:0] DEFAULT_DIV  = DIV_W'(sdcard_clkgen_pkg::DEFAULT_DIV),
    parameter int               STABLE_EDGES = 8
) (
    input  logic                    PCLK_i,
    input  logic                    PRESETn_i,
    input  logic [NUM_CH-1:0]       ch_en_i,
    input  logic [NUM_CH-1:0]       pause_i,
    input  logic [NUM_CH*DIV_W-1:0] div_i,
    input  logic [NUM_CH-1:0]       div_load_i,
    input  logic                    power_down_i,
    output logic [NUM_CH-1:0]       sd_clk_o,
    output logic [NUM_CH-1:0]       sd_clk_rise_o,
    output logic [NUM_CH-1:0]       sd_clk_fall_o,
    output logic [NUM_CH-1:0]       div_ack_o,
    output logic [NUM_CH-1:0]       clk_stable_o,
    output logic [NUM_CH-1:0]       running_o
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        sdcard_clkgen_channel #(
            .DIV_W        (DIV_W),
            .DEFAULT_DIV  (DEFAULT_DIV),
            .STABLE_EDGES (STABLE_EDGES)
        ) u_channel (
            .clk          (PCLK_i),
            .rst_n        (PRESETn_i),
            .i_en         (ch_en_i[c]),
            .i_pause      (pause_i[c]),
            .i_power_down (power_down_i),
            .i_div        (div_i[c*DIV_W +: DIV_W]),
            .i_div_load   (div_load_i[c]),
            .o_sd_clk     (sd_clk_o[c]),
            .o_rise       (sd_clk_rise_o[c]),
            .o_fall       (sd_clk_fall_o[c]),
            .o_ack        (div_ack_o[c]),
            .o_stable     (clk_stable_o[c]),
            .o_running    (running_o[c])
        );
    end

endmodule

// File: tb/tb_sdcard_multi_clock_generator.sv
// Self-checking bench: directed scenarios plus random stimulus, every cycle compared
// against a half-period timing model of each SD clock channel.
module tb_sdcard_multi_clock_generator;

    localparam int NCH = 2;
    localparam int DW  = 16;
    localparam int SE  = 8;

    logic                pclk = 1'b0;
    logic                rstn = 1'b1;
    logic [NCH-1:0]      en = '0, pause = '0, load = '0;
    logic [NCH*DW-1:0]   div = '0;
    logic                pd = 1'b0;
    logic [NCH-1:0]      sd_clk_o, sd_clk_rise_o, sd_clk_fall_o, div_ack_o, clk_stable_o, running_o;

    int n_checks = 0;
    int n_fail   = 0;

    // model: mode 0 idle, 1 running, 2 finishing high half; t = cycles spent in current half
    int m_mode[NCH], m_lvl[NCH], m_t[NCH], m_a[NCH], m_p[NCH], m_pend[NCH], m_edges[NCH];
    int m_rise[NCH], m_fall[NCH], m_ack[NCH];

    sdcard_multi_clock_generator dut (
        .PCLK_i        (pclk),
        .PRESETn_i     (rstn),
        .ch_en_i       (en),
        .pause_i       (pause),
        .div_i         (div),
        .div_load_i    (load),
        .power_down_i  (pd),
        .sd_clk_o      (sd_clk_o),
        .sd_clk_rise_o (sd_clk_rise_o),
        .sd_clk_fall_o (sd_clk_fall_o),
        .div_ack_o     (div_ack_o),
        .clk_stable_o  (clk_stable_o),
        .running_o     (running_o)
    );

    always #5 pclk = ~pclk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_mode[c] = 0; m_lvl[c] = 0; m_t[c] = 0; m_a[c] = 124; m_p[c] = 124;
            m_pend[c] = 0; m_edges[c] = 0; m_rise[c] = 0; m_fall[c] = 0; m_ack[c] = 0;
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < NCH; c++) begin
            int run;
            int apply;
            run = (en[c] && !pause[c] && !pd) ? 1 : 0;
            apply = 0;
            m_rise[c] = 0;
            m_fall[c] = 0;
            if (pd && m_mode[c] != 0) begin
                m_fall[c] = m_lvl[c];
                m_lvl[c]  = 0;
                m_mode[c] = 0;
            end else if (m_mode[c] == 0) begin
                apply = m_pend[c];
                if (run != 0) begin m_mode[c] = 1; m_lvl[c] = 0; m_t[c] = 0; end
            end else if (m_mode[c] == 1 && m_lvl[c] == 0) begin
                if (run == 0) m_mode[c] = 0;
                else if (m_t[c] == m_a[c]) begin m_lvl[c] = 1; m_t[c] = 0; m_rise[c] = 1; end
                else m_t[c]++;
            end else begin
                if (m_t[c] == m_a[c]) begin
                    m_lvl[c] = 0; m_fall[c] = 1; apply = m_pend[c]; m_t[c] = 0;
                    if (run == 0 || m_mode[c] == 2) m_mode[c] = 0;
                end else begin
                    m_t[c]++;
                    if (run == 0) m_mode[c] = 2;
                end
            end
            m_ack[c] = apply;
            if (apply != 0) begin m_a[c] = m_p[c]; m_pend[c] = 0; end
            if (load[c]) begin m_p[c] = int'(div[c*DW +: DW]); m_pend[c] = 1; end
            if (apply != 0 || pd || m_mode[c] != 1) m_edges[c] = 0;
            else if (m_rise[c] != 0 && m_edges[c] < SE) m_edges[c]++;
        end
    endtask

    task automatic compare_all();
        for (int c = 0; c < NCH; c++) begin
            check_eq($sformatf("sd_clk[%0d]", c),  32'(sd_clk_o[c]),      32'(m_lvl[c]));
            check_eq($sformatf("rise[%0d]", c),    32'(sd_clk_rise_o[c]), 32'(m_rise[c]));
            check_eq($sformatf("fall[%0d]", c),    32'(sd_clk_fall_o[c]), 32'(m_fall[c]));
            check_eq($sformatf("ack[%0d]", c),     32'(div_ack_o[c]),     32'(m_ack[c]));
            check_eq($sformatf("stable[%0d]", c),  32'(clk_stable_o[c]),  32'(m_edges[c] == SE));
            check_eq($sformatf("running[%0d]", c), 32'(running_o[c]),     32'(m_mode[c] == 1));
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic measure_period(input int c, input int bound, output int n);
        int k;
        k = 0;
        while (!sd_clk_rise_o[c] && k < bound) begin tick(); k++; end
        n = 0;
        do begin tick(); n++; end while (!sd_clk_rise_o[c] && n < bound);
    endtask

    task automatic count_rises(input int c, input int cycles, output int r);
        r = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (sd_clk_rise_o[c]) r++;
        end
    endtask

    initial begin
        int n;
        int r;
        int r1;
        model_reset();
        #1 rstn = 1'b0;
        #2;
        compare_all();
        @(negedge pclk);
        @(negedge pclk);
        rstn = 1'b1;
        @(posedge pclk);
        #1;

        // default divider: first rise, period, stability after 8 rises
        en[0] = 1'b1;
        tick();
        check_eq("running_after_enable", 32'(running_o[0]), 32'd1);
        n = 0;
        do begin tick(); n++; end while (!sd_clk_o[0] && n < 400);
        check_eq("first_rise_latency", n, 125);
        measure_period(0, 600, n);
        check_eq("period_div124", n, 250);
        r = 2;
        n = 0;
        while (!clk_stable_o[0] && n < 3000) begin
            tick(); n++;
            if (sd_clk_rise_o[0]) r++;
        end
        check_eq("rises_to_stable", r, 8);

        // divider 3 loaded while high, applied at the fall
        div[0 +: DW] = 16'd3; load[0] = 1'b1;
        tick();
        load[0] = 1'b0;
        n = 0;
        while (!div_ack_o[0] && n < 300) begin tick(); n++; end
        check_eq("ack_with_fall", 32'(sd_clk_fall_o[0]), 32'd1);
        measure_period(0, 100, n);
        check_eq("period_div3", n, 8);

        // two loads before a fall: latest wins, single ack
        div[0 +: DW] = 16'd5; load[0] = 1'b1;
        tick();
        div[0 +: DW] = 16'd9;
        tick();
        load[0] = 1'b0;
        r = 0;
        for (int i = 0; i < 30; i++) begin tick(); if (div_ack_o[0]) r++; end
        check_eq("single_ack", r, 1);
        measure_period(0, 100, n);
        check_eq("period_div9", n, 20);

        // disable mid-high: low at the scheduled fall, no further rise
        tick(); tick(); tick();
        en[0] = 1'b0;
        n = 0;
        do begin tick(); n++; end while (sd_clk_o[0] && n < 50);
        check_eq("park_fall_latency", n, 7);
        count_rises(0, 30, r);
        check_eq("no_rise_after_park", r, 0);

        // disable mid-low: no rise, running drops next cycle
        en[0] = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        en[0] = 1'b0;
        tick();
        check_eq("running_drop_mid_low", 32'(running_o[0]), 32'd0);
        count_rises(0, 20, r);
        check_eq("no_rise_mid_low", r, 0);

        // power down while high, restart with retained divider
        en = 2'b11;
        n = 0;
        while (!sd_clk_rise_o[0] && n < 100) begin tick(); n++; end
        tick();
        pd = 1'b1;
        tick();
        check_eq("pd_clk_low", 32'(sd_clk_o), 32'd0);
        pd = 1'b0;
        measure_period(0, 100, n);
        check_eq("period_after_pd", n, 20);

        // concurrent fast channels, pause only channel 1
        en = 2'b00;
        for (int i = 0; i < 300; i++) tick();
        div[0 +: DW] = 16'd0; div[DW +: DW] = 16'd1; load = 2'b11;
        tick();
        load = 2'b00;
        tick();
        en = 2'b11;
        measure_period(0, 20, n);
        check_eq("period_ch0_div0", n, 2);
        measure_period(1, 20, n);
        check_eq("period_ch1_div1", n, 4);
        pause[1] = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        r = 0; r1 = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (sd_clk_rise_o[0]) r++;
            if (sd_clk_rise_o[1]) r1++;
        end
        check_eq("ch0_rises_during_pause1", r, 10);
        check_eq("ch1_rises_while_paused", r1, 0);
        pause[1] = 1'b0;

        // random traffic, with one asynchronous reset in the middle
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 49) == 0) en[c] = ~en[c];
                if ($urandom_range(0, 59) == 0) pause[c] = ~pause[c];
                load[c] = ($urandom_range(0, 29) == 0);
                div[c*DW +: DW] = DW'($urandom_range(0, 4));
            end
            if (pd) pd = ($urandom_range(0, 3) != 0);
            else    pd = ($urandom_range(0, 199) == 0);
            if (i == 1500) begin
                #2 rstn = 1'b0;
                #1;
                model_reset();
                compare_all();
                #2 rstn = 1'b1;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sdcard_multi_clock_generator.md
# sdcard_multi_clock_generator

Parametrised multi-slot SD clock generator that produces NUM_CH independent SD card clocks from the APB clock. Each channel has its own divider. Divider changes are glitch-free and take effect only at a falling edge. The clock stops parked low on disable or pause, and each channel reports a stability flag. The block sits between the controller register file and the per-slot SD command/data engines. The rise/fall strobes let those engines sample and drive in the PCLK domain.

## Interface
- NUM_CH, 2, number of independent SD clock channels (1..8)
- DIV_W, 16, divider width
- DEFAULT_DIV, 16'd124, divider after reset (400 kHz at 100 MHz PCLK)
- STABLE_EDGES, 8, consecutive rising edges with no change before clk_stable_o asserts
- PCLK_i  input  1  APB clock; the block's only clock
- PRESETn_i  input  1  reset, asynchronous, active-low
- ch_en_i  input  NUM_CH  per-channel clock enable (level)
- pause_i  input  NUM_CH  per-channel clock stop request from the data path, for buffer backpressure (level)
- div_i  input  NUM_CH*DIV_W  divider; channel c uses [c*DIV_W +: DIV_W]
- div_load_i  input  NUM_CH  one-cycle pulse that captures div_i of channel c
- power_down_i  input  1  global forced stop
- sd_clk_o  output  NUM_CH  SD clocks, registered
- sd_clk_rise_o  output  NUM_CH  high in the first cycle sd_clk_o[c] reads 1
- sd_clk_fall_o  output  NUM_CH  high in the first cycle sd_clk_o[c] reads 0 after a high
- div_ack_o  output  NUM_CH  one-cycle pulse when the pending divider becomes active
- clk_stable_o  output  NUM_CH  channel running at its active divider for STABLE_EDGES rises
- running_o  output  NUM_CH  channel is in CH_LOW or CH_HIGH

## Operation
- Per-channel registers: active divider A, pending divider P plus pending flag, down-counter, state, stable edge counter.
- Output frequency: sd_clk period = 2*(A+1) PCLK cycles. A=0 gives PCLK/2. No divide-by-zero case exists.
- The counter decrements each cycle in CH_LOW and CH_HIGH. At 0 the clock toggles and the counter reloads with A.
- States:
  - CH_OFF: clock low, counter held at A.
  - CH_LOW: counting toward a rise.
  - CH_HIGH: counting toward a fall.
  - CH_PARK: high half completing, then stop.
- Transitions:
  - CH_OFF→CH_LOW when ch_en_i & !pause_i & !power_down_i.
  - CH_LOW→CH_HIGH at count 0 if run is still requested; otherwise CH_LOW→CH_OFF immediately, with no rise.
  - CH_HIGH→CH_LOW at count 0 (fall).
  - CH_HIGH→CH_PARK when run is withdrawn mid-high.
  - CH_PARK→CH_OFF at count 0 (fall).
- Divider load: div_load_i sets P=div_i[c] and sets the pending flag.
  - P is applied (A=P) at the cycle of a falling toggle, or on the next cycle while in CH_OFF.
  - div_ack_o pulses in the cycle A updates.
  - A second load before apply overwrites P (latest wins) and produces one ack only.
  - A load in the same cycle as an apply is kept pending for the next fall.
- Stability: the edge counter increments on each rise and saturates at STABLE_EDGES; clk_stable_o = (count == STABLE_EDGES).
  - Cleared on divider apply, entry to CH_OFF or CH_PARK, and power_down_i.
- Power down: power_down_i forces every channel to CH_OFF with sd_clk_o=0 on the next edge, regardless of phase; glitch is acceptable because card power is off.
  - The pending divider is retained and applied in CH_OFF.
  - Power down has priority over all other inputs.
- Simultaneous disable and counter 0 in CH_LOW: the channel stops and no rise occurs.

## Timing
- Reset values:
  - sd_clk_o, sd_clk_rise_o, sd_clk_fall_o, div_ack_o, clk_stable_o, running_o all 0.
  - State CH_OFF, A=DEFAULT_DIV, counter=DEFAULT_DIV, no pending.
- Start latency: ch_en_i sampled high at edge N gives CH_LOW at N+1, and the first rise is visible A+1 cycles later.
- Stop latency: at most A+1 cycles from run withdrawal to sd_clk_o low.
- All outputs are registered. The strobes are coincident with the sd_clk_o change.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronous).

## Structure
- Package sdcard_clkgen_pkg: channel state enum (CH_OFF, CH_LOW, CH_HIGH, CH_PARK), DEFAULT_DIV constant.
- Sub-module sdcard_clkgen_channel: one channel's FSM, counter, pending/active divider and stability counter. The top generate-instantiates NUM_CH of them and ties in power_down_i.

## Test plan
- Reset, ch_en_i[0]=1, no loads: first rise 125 cycles after enable, period 250 cycles; clk_stable_o[0] high after the 8th rise.
- div_load_i[0] with div_i=3 while high: A unchanged until the next fall, div_ack_o pulses at that fall, subsequent period 8 cycles, clk_stable_o drops then reasserts after 8 rises.
- Two loads (5 then 9) before a fall: one ack, A=9, period 20.
- ch_en_i deasserted mid-high with A=9: sd_clk_o goes low at the scheduled fall with no extra rise; deasserted mid-low: no rise and running_o drops the next cycle.
- power_down_i pulsed while high: sd_clk_o=0 on the next edge for both channels; on release, channels restart with retained divider.
- NUM_CH=2, channel 0 A=0 and channel 1 A=1 running concurrently: periods 2 and 4, independent strobes, pause_i[1] stops only channel 1.
